gemm_tile_engine: RTL and testbench

GEMM_TILE_ENGINE -- requirements
Module: gemm_tile_engine

---
 rtl/gemm_tile_engine.sv | 167 ++++++++++++++++
 tb/tb_gemm_tile_engine.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gemm_tile_engine.sv
// gemm_tile_engine: computes C = A x B one row at a time, with COLS MAC lanes working in parallel.
// Build option GEMM_TILE_SAT_EN: each accumulate saturates instead of wrapping.
module gemm_tile_engine #(
    parameter int ROWS     = 16,
    parameter int COLS     = 16,
    parameter int K_MAX    = 2048,
    parameter int DATA_W_P = 8,
    parameter int ACC_W_P  = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [$clog2(ROWS+1)-1:0]         cfg_m,
    input  logic [$clog2(COLS+1)-1:0]         cfg_n,
    input  logic [$clog2(K_MAX+1)-1:0]        cfg_k,
    output logic                              busy,
    output logic                              done,
    input  logic signed [DATA_W_P-1:0]        A_buf [ROWS][K_MAX],
    input  logic signed [DATA_W_P-1:0]        B_buf [K_MAX][COLS],
    output logic signed [ACC_W_P-1:0]         C_buf [ROWS][COLS]
);

    // state | meaning
    // IDLE  | waiting for start; dimensions latched (and clamped) on start
    // CLEAR | zero all lane accumulators and the k counter for the current row
    // MAC   | one reduction step per cycle, k cycles per row
    // WRITE | copy accumulators into C_buf[row], zero the unused columns
    // DONE  | one-cycle completion pulse, start ignored
    typedef enum logic [2:0] {IDLE, CLEAR, MAC, WRITE, DONE} state_t;

    localparam int M_W  = $clog2(ROWS+1);
    localparam int N_W  = $clog2(COLS+1);
    localparam int K_W  = $clog2(K_MAX+1);
    localparam int RI_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int KI_W = (K_MAX > 1) ? $clog2(K_MAX) : 1;

    state_t                    state_q, state_d;
    logic [M_W-1:0]            m_q, m_d;
    logic [N_W-1:0]            n_q, n_d;
    logic [K_W-1:0]            k_lim_q, k_lim_d;
    logic [RI_W-1:0]           row_q, row_d;
    logic [K_W-1:0]            k_q, k_d;
    logic signed [ACC_W_P-1:0] acc_q [COLS];
    logic signed [ACC_W_P-1:0] acc_d [COLS];
    logic signed [2*DATA_W_P-1:0] prod [COLS];

    logic [M_W-1:0]  m_clamp;
    logic [N_W-1:0]  n_clamp;
    logic [K_W-1:0]  k_clamp;
    logic [KI_W-1:0] k_idx;

    assign m_clamp = (cfg_m > M_W'(ROWS))  ? M_W'(ROWS)  : cfg_m;
    assign n_clamp = (cfg_n > N_W'(COLS))  ? N_W'(COLS)  : cfg_n;
    assign k_clamp = (cfg_k > K_W'(K_MAX)) ? K_W'(K_MAX) : cfg_k;
    assign k_idx   = k_q[KI_W-1:0];

    function automatic logic signed [ACC_W_P-1:0] acc_add(
        input logic signed [ACC_W_P-1:0] a,
        input logic signed [ACC_W_P-1:0] b
    );
`ifdef GEMM_TILE_SAT_EN
        logic [ACC_W_P:0] s;
        s = {a[ACC_W_P-1], a} + {b[ACC_W_P-1], b};
        // Top two bits disagree only when the true sum left the representable range.
        if (s[ACC_W_P] != s[ACC_W_P-1])
            return s[ACC_W_P] ? {1'b1, {(ACC_W_P-1){1'b0}}} : {1'b0, {(ACC_W_P-1){1'b1}}};
        return s[ACC_W_P-1:0];
`else
        return a + b;
`endif
    endfunction

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        n_d     = n_q;
        k_lim_d = k_lim_q;
        row_d   = row_q;
        k_d     = k_q;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    m_d     = m_clamp;
                    n_d     = n_clamp;
                    k_lim_d = k_clamp;
                    row_d   = '0;
                    if (m_clamp == '0 || n_clamp == '0 || k_clamp == '0)
                        state_d = DONE;
                    else
                        state_d = CLEAR;
                end
            end
            CLEAR: begin
                busy    = 1'b1;
                k_d     = '0;
                state_d = MAC;
            end
            MAC: begin
                busy = 1'b1;
                k_d  = k_q + K_W'(1);
                if (k_q == k_lim_q - K_W'(1))
                    state_d = WRITE;
            end
            WRITE: begin
                busy = 1'b1;
                if (M_W'(row_q) + M_W'(1) >= m_q) begin
                    state_d = DONE;
                end else begin
                    row_d   = row_q + RI_W'(1);
                    state_d = CLEAR;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        for (int j = 0; j < COLS; j++) begin
            prod[j]  = A_buf[row_q][k_idx] * B_buf[k_idx][j];
            acc_d[j] = acc_q[j];
            if (state_q == CLEAR)
                acc_d[j] = '0;
            else if (state_q == MAC && N_W'(j) < n_q)
                acc_d[j] = acc_add(acc_q[j], ACC_W_P'(prod[j]));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            m_q     <= '0;
            n_q     <= '0;
            k_lim_q <= '0;
            row_q   <= '0;
            k_q     <= '0;
            for (int j = 0; j < COLS; j++)
                acc_q[j] <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            n_q     <= n_d;
            k_lim_q <= k_lim_d;
            row_q   <= row_d;
            k_q     <= k_d;
            for (int j = 0; j < COLS; j++)
                acc_q[j] <= acc_d[j];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ROWS; i++)
                for (int j = 0; j < COLS; j++)
                    C_buf[i][j] <= '0;
        end else if (state_q == WRITE) begin
            for (int j = 0; j < COLS; j++)
                C_buf[row_q][j] <= (N_W'(j) < n_q) ? acc_q[j] : '0;
        end
    end

endmodule

// File: tb/tb_gemm_tile_engine.sv
// Directed bench for gemm_tile_engine: reference-model scoreboard, latency and busy/done checks.
// Honours GEMM_TILE_SAT_EN for the expected value of the narrow-accumulator case.
module tb_gemm_tile_engine;

    typedef struct {
        int     r;
        int     c;
        longint v;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic               start;
    logic [4:0]         cfg_m;
    logic [4:0]         cfg_n;
    logic [11:0]        cfg_k;
    logic               busy;
    logic               done;
    logic signed [7:0]  A [16][2048];
    logic signed [7:0]  B [2048][16];
    logic signed [31:0] C [16][16];

    logic               start16;
    logic [1:0]         cfg_m16;
    logic [1:0]         cfg_n16;
    logic [2:0]         cfg_k16;
    logic               busy16;
    logic               done16;
    logic signed [7:0]  A16 [2][4];
    logic signed [7:0]  B16 [4][2];
    logic signed [15:0] C16 [2][2];

    logic signed [31:0] Cm [16][16];
    exp_t               exp_q [$];
    int                 done_q [$];
    int                 checks = 0;
    int                 errors = 0;

`ifdef GEMM_TILE_SAT_EN
    localparam longint EXP16 = 32767;
`else
    localparam longint EXP16 = -1020;
`endif

    gemm_tile_engine dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .cfg_m (cfg_m),
        .cfg_n (cfg_n),
        .cfg_k (cfg_k),
        .busy  (busy),
        .done  (done),
        .A_buf (A),
        .B_buf (B),
        .C_buf (C)
    );

    gemm_tile_engine #(.ROWS(2), .COLS(2), .K_MAX(4), .DATA_W_P(8), .ACC_W_P(16)) dut16 (
        .clk   (clk),
        .rst   (rst),
        .start (start16),
        .cfg_m (cfg_m16),
        .cfg_n (cfg_n16),
        .cfg_k (cfg_k16),
        .busy  (busy16),
        .done  (done16),
        .A_buf (A16),
        .B_buf (B16),
        .C_buf (C16)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, $signed(obs), $signed(exp_v));
        end
    endtask

    // Model the tile, queue the full expected C_buf and done cycle, then run it.
    // pulse_cyc re-asserts start (with other cfg values) at that cycle; it must be ignored.
    task automatic run_tile(input int m, input int n, input int k, input int pulse_cyc);
        int     exp_done;
        int     cyc;
        int     dones;
        int     d;
        bit     nz;
        longint s;
        exp_t   e;
        nz = (m != 0) && (n != 0) && (k != 0);
        if (nz) begin
            for (int r = 0; r < m; r++)
                for (int c = 0; c < 16; c++) begin
                    s = 0;
                    if (c < n)
                        for (int kk = 0; kk < k; kk++)
                            s += longint'(A[r][kk]) * longint'(B[kk][c]);
                    Cm[r][c] = s[31:0];
                end
        end
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) begin
                e.r = r;
                e.c = c;
                e.v = longint'(Cm[r][c]);
                exp_q.push_back(e);
            end
        exp_done = nz ? m * (k + 2) + 1 : 1;
        done_q.push_back(exp_done);

        cfg_m = 5'(m);
        cfg_n = 5'(n);
        cfg_k = 12'(k);
        start = 1'b1;
        tick();
        start = 1'b0;
        cfg_m = 5'd16;
        cfg_n = 5'd16;
        cfg_k = 12'd5;
        cyc   = 1;
        dones = 0;
        while (cyc <= exp_done + 8) begin
            chk("busy", 64'(busy), 64'(nz && cyc < exp_done));
            start = (cyc == pulse_cyc);
            if (done === 1'b1) begin
                dones++;
                if (done_q.size() > 0) begin
                    d = done_q.pop_front();
                    chk("done_cycle", 64'(cyc), 64'(d));
                end
                while (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk($sformatf("C_buf[%0d][%0d]", e.r, e.c), C[e.r][e.c], e.v);
                end
            end
            tick();
            cyc++;
        end
        start = 1'b0;
        chk("done_count", 64'(dones), 64'd1);
        exp_q.delete();
        done_q.delete();
    endtask

    initial begin
        int   cyc;
        int   dones;
        exp_t e;

        rst     = 1'b1;
        start   = 1'b1;
        start16 = 1'b1;
        cfg_m   = 5'd2;
        cfg_n   = 5'd2;
        cfg_k   = 12'd2;
        cfg_m16 = '0;
        cfg_n16 = '0;
        cfg_k16 = '0;
        for (int r = 0; r < 16; r++)
            for (int kk = 0; kk < 2048; kk++) begin
                A[r][kk] = '0;
                B[kk][r] = '0;
            end
        for (int r = 0; r < 2; r++)
            for (int kk = 0; kk < 4; kk++) begin
                A16[r][kk] = 8'sd127;
                B16[kk][r] = 8'sd127;
            end
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                Cm[r][c] = '0;
        tick();
        tick();
        start   = 1'b0;
        start16 = 1'b0;
        rst     = 1'b0;
        tick();

        // Reset state, including start held during reset.
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_busy16", 64'(busy16), 64'd0);
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                chk("reset_C_buf", C[r][c], 64'd0);

        // 2x2x2 worked example.
        A[0][0] = 8'sd1; A[0][1] = 8'sd2; A[1][0] = 8'sd3; A[1][1] = 8'sd4;
        B[0][0] = 8'sd5; B[0][1] = 8'sd6; B[1][0] = 8'sd7; B[1][1] = 8'sd8;
        run_tile(2, 2, 2, -1);
        chk("ex_C00", C[0][0], 64'd19);
        chk("ex_C01", C[0][1], 64'd22);
        chk("ex_C10", C[1][0], 64'd43);
        chk("ex_C11", C[1][1], 64'd50);

        // Full tile, most negative operands.
        for (int r = 0; r < 16; r++)
            for (int kk = 0; kk < 64; kk++) begin
                A[r][kk] = -8'sd128;
                B[kk][r] = -8'sd128;
            end
        run_tile(16, 16, 64, -1);
        chk("full_C_corner", C[15][15], 64'd1048576);

        // Partial tile over a pre-filled C_buf.
        for (int r = 0; r < 16; r++) begin
            A[r][0] = 8'(r + 1);
            B[0][r] = 8'(r - 2);
        end
        run_tile(3, 5, 1, -1);
        chk("partial_pad_col", C[2][9], 64'd0);
        chk("partial_untouched_row", C[3][0], 64'd1048576);

        // Zero depth: immediate done, nothing written.
        run_tile(2, 2, 0, -1);

        // start during busy, then start during DONE: both ignored.
        run_tile(2, 2, 3, 3);
        run_tile(1, 1, 1, 4);

        // Reset mid-tile at cycle 5.
        cfg_m = 5'd4;
        cfg_n = 5'd16;
        cfg_k = 12'd8;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc   = 1;
        while (cyc < 5) begin
            chk("abort_busy_pre", 64'(busy), 64'd1);
            tick();
            cyc++;
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1 || busy === 1'b1)
                dones++;
            tick();
        end
        chk("abort_no_activity", 64'(dones), 64'd0);
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) begin
                Cm[r][c] = '0;
                chk("abort_C_buf", C[r][c], 64'd0);
            end

        // 16-bit accumulator, oversize cfg clamps to 2x2x4; sum 64516 overflows.
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++) begin
                e.r = r;
                e.c = c;
                e.v = EXP16;
                exp_q.push_back(e);
            end
        cfg_m16 = 2'd3;
        cfg_n16 = 2'd3;
        cfg_k16 = 3'd7;
        start16 = 1'b1;
        tick();
        start16 = 1'b0;
        cyc = 1;
        while (done16 !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
        chk("acc16_done_cycle", 64'(cyc), 64'd13);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk($sformatf("acc16_C[%0d][%0d]", e.r, e.c), C16[e.r][e.c], e.v);
        end
        tick();
        chk("acc16_busy_after", 64'(busy16), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
